multicore_mem_ctrl: RTL

Parametrised control and memory-routing layer for an N-core array of simple processors. It sits between the cores, their N private instruction RAMs and one N-port data RAM. The external host loads programs and data, runs the array, and reads results back. An explicit, mutually exclusive mode FSM with a request/acknowledge handshake replaces independent start flags. It adds per-core enable, automatic halt detection, a run-cycle counter and a pipelined external readback path with a valid strobe.

---
 rtl/multicore_pkg.sv | 28 ++
 rtl/mc_mode_fsm.sv | 69 ++++++
 rtl/multicore_mem_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multicore_pkg.sv
// Shared mode encoding, default parameter values and helpers for the
// multicore memory controller.
package multicore_pkg;

   localparam int NCORES_DEF = 4;
   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 16;
   localparam int PC_W_DEF   = 16;
   localparam int RD_LAT_DEF = 1;

   typedef enum logic [2:0] {
      MODE_IDLE      = 3'd0,
      MODE_LOAD_IRAM = 3'd1,
      MODE_LOAD_DRAM = 3'd2,
      MODE_RUN       = 3'd3,
      MODE_READBACK  = 3'd4
   } mode_e;

   // Width of the host DRAM port selector; a single core still needs one bit.
   function automatic int port_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic mode_valid(input logic [2:0] m);
      return (m <= 3'(MODE_READBACK));
   endfunction

endpackage

// File: rtl/mc_mode_fsm.sv
// Mode register with request/acknowledge handshake, halt-driven RUN exit
// and a saturating RUN cycle counter.
module mc_mode_fsm
   import multicore_pkg::*;
#(
   parameter int NCORES = NCORES_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mode_req,
   input  logic [2:0]        mode,
   input  logic              rd_busy,
   input  logic [NCORES-1:0] core_en,
   input  logic [NCORES-1:0] core_halt,
   output mode_e             cur_mode,
   output logic              mode_ack,
   output logic              mode_err,
   output logic [NCORES-1:0] run_en,
   output logic              run_done,
   output logic [31:0]       run_cycles
);

   logic halt_exit;
   logic accept;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign halt_exit = (cur_mode == MODE_RUN) && ((core_halt & run_en) == run_en);
   // The pulse cycle is skipped so a host dropping mode_req on seeing ack is not served twice.
   assign accept    = mode_req && !rd_busy && !mode_ack && !mode_err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_mode   <= MODE_IDLE;
         mode_ack   <= 1'b0;
         mode_err   <= 1'b0;
         run_en     <= '0;
         run_done   <= 1'b0;
         run_cycles <= '0;
      end else begin
         mode_ack <= 1'b0;
         mode_err <= 1'b0;
         run_done <= 1'b0;
         if (cur_mode == MODE_RUN)
            run_cycles <= sat_inc(run_cycles);
         if (halt_exit) begin
            cur_mode <= MODE_IDLE;
            run_en   <= '0;
            run_done <= 1'b1;
         end else if (accept) begin
            if (mode_valid(mode)) begin
               cur_mode <= mode_e'(mode);
               mode_ack <= 1'b1;
               if (mode == 3'(MODE_RUN)) begin
                  run_en     <= core_en;
                  run_cycles <= '0;
               end else begin
                  run_en <= '0;
               end
            end else begin
               mode_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/multicore_mem_ctrl.sv
// Routes host and core traffic to the IRAMs and the N-port DRAM according to
// the current mode, and returns host reads through a valid-tagged pipeline.
module multicore_mem_ctrl
   import multicore_pkg::*;
#(
   parameter int NCORES = NCORES_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int PC_W   = PC_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       mode_req,
   input  logic [2:0]                 mode,
   output logic                       mode_ack,
   output logic                       mode_err,
   output logic [2:0]                 cur_mode,
   input  logic [NCORES-1:0]          core_en,
   input  logic [ADDR_W-1:0]          ext_addr,
   input  logic [DATA_W-1:0]          ext_wdata,
   input  logic                       ext_we,
   input  logic                       ext_re,
   input  logic [NCORES-1:0]          ext_core_sel,
   input  logic [port_w(NCORES)-1:0]  ext_port,
   output logic [DATA_W-1:0]          ext_rdata,
   output logic                       ext_rvalid,
   input  logic [NCORES*PC_W-1:0]     core_pc,
   input  logic [NCORES*PC_W-1:0]     core_ar,
   input  logic [NCORES*DATA_W-1:0]   core_wdata,
   input  logic [NCORES-1:0]          core_iread,
   input  logic [NCORES-1:0]          core_dread,
   input  logic [NCORES-1:0]          core_dwrite,
   input  logic [NCORES-1:0]          core_halt,
   output logic [NCORES-1:0]          run_en,
   output logic [NCORES*ADDR_W-1:0]   iram_addr,
   output logic [NCORES-1:0]          iram_we,
   output logic [NCORES-1:0]          iram_re,
   output logic [DATA_W-1:0]          iram_wdata,
   output logic [NCORES*ADDR_W-1:0]   dram_addr,
   output logic [NCORES*DATA_W-1:0]   dram_wdata,
   output logic [NCORES-1:0]          dram_we,
   output logic [NCORES-1:0]          dram_re,
   input  logic [NCORES*DATA_W-1:0]   dram_rdata,
   output logic                       run_done,
   output logic [31:0]                run_cycles
);

   localparam int PORT_W = port_w(NCORES);

   mode_e                    mode_q;
   logic                     rd_busy;
   logic                     port_ok;
   logic                     rd_issue;
   logic [NCORES-1:0]        iram_we_n, iram_re_n, dram_we_n, dram_re_n;
   logic [NCORES*ADDR_W-1:0] iram_addr_n, dram_addr_n;
   logic [DATA_W-1:0]        iram_wdata_n;
   logic [NCORES*DATA_W-1:0] dram_wdata_n;
   logic [RD_LAT:0]          rd_vld_p;
   logic [PORT_W-1:0]        rd_port_p [RD_LAT+1];

   assign cur_mode = mode_q;
   assign rd_busy  = |rd_vld_p;
   assign port_ok  = int'(ext_port) < NCORES;

   mc_mode_fsm #(.NCORES(NCORES)) u_mode_fsm (
      .clock      (clock),
      .reset      (reset),
      .mode_req   (mode_req),
      .mode       (mode),
      .rd_busy    (rd_busy),
      .core_en    (core_en),
      .core_halt  (core_halt),
      .cur_mode   (mode_q),
      .mode_ack   (mode_ack),
      .mode_err   (mode_err),
      .run_en     (run_en),
      .run_done   (run_done),
      .run_cycles (run_cycles)
   );

   always_comb begin
      iram_we_n    = '0;
      iram_re_n    = '0;
      iram_addr_n  = '0;
      iram_wdata_n = '0;
      dram_we_n    = '0;
      dram_re_n    = '0;
      dram_addr_n  = '0;
      dram_wdata_n = '0;
      rd_issue     = 1'b0;
      case (mode_q)
         MODE_LOAD_IRAM: begin
            if (ext_we) begin
               iram_we_n    = ext_core_sel;
               iram_addr_n  = {NCORES{ext_addr}};
               iram_wdata_n = ext_wdata;
            end
         end
         MODE_LOAD_DRAM: begin
            if (ext_we && port_ok) begin
               dram_we_n[ext_port]                             = 1'b1;
               dram_addr_n[int'(ext_port)*ADDR_W +: ADDR_W]    = ext_addr;
               dram_wdata_n[int'(ext_port)*DATA_W +: DATA_W]   = ext_wdata;
            end
         end
         MODE_READBACK: begin
            if (ext_re && port_ok) begin
               dram_re_n[ext_port]                             = 1'b1;
               dram_addr_n[int'(ext_port)*ADDR_W +: ADDR_W]    = ext_addr;
               rd_issue                                        = 1'b1;
            end
         end
         MODE_RUN: begin
            for (int i = 0; i < NCORES; i++) begin
               if (run_en[i]) begin
                  iram_addr_n[i*ADDR_W +: ADDR_W]  = core_pc[i*PC_W +: ADDR_W];
                  iram_re_n[i]                     = core_iread[i];
                  dram_addr_n[i*ADDR_W +: ADDR_W]  = core_ar[i*PC_W +: ADDR_W];
                  dram_wdata_n[i*DATA_W +: DATA_W] = core_wdata[i*DATA_W +: DATA_W];
                  dram_we_n[i]                     = core_dwrite[i];
                  dram_re_n[i]                     = core_dread[i];
               end
            end
         end
         default: ;
      endcase
   end

   // Stage p0: registered memory-side outputs; a host read enters the valid pipe here
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         iram_we    <= '0;
         iram_re    <= '0;
         iram_addr  <= '0;
         iram_wdata <= '0;
         dram_we    <= '0;
         dram_re    <= '0;
         dram_addr  <= '0;
         dram_wdata <= '0;
      end else begin
         iram_we    <= iram_we_n;
         iram_re    <= iram_re_n;
         iram_addr  <= iram_addr_n;
         iram_wdata <= iram_wdata_n;
         dram_we    <= dram_we_n;
         dram_re    <= dram_re_n;
         dram_addr  <= dram_addr_n;
         dram_wdata <= dram_wdata_n;
      end
   end

   // Stages p1..pRD_LAT track the DRAM latency; the last stage captures read data
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_vld_p   <= '0;
         ext_rvalid <= 1'b0;
         ext_rdata  <= '0;
      end else begin
         rd_vld_p   <= {rd_vld_p[RD_LAT-1:0], rd_issue};
         ext_rvalid <= rd_vld_p[RD_LAT];
         if (rd_vld_p[RD_LAT])
            ext_rdata <= dram_rdata[int'(rd_port_p[RD_LAT])*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clock) begin
      rd_port_p[0] <= ext_port;
      for (int k = 1; k <= RD_LAT; k++)
         rd_port_p[k] <= rd_port_p[k-1];
   end

endmodule
